// File: rtl/dvp_gen.sv
// dvp_gen: DVP-style test-pattern video timing generator.
//
// Produces href / vsync / data / frame_start for a programmable raster.
// Timing parameters and the pattern selection are programmed through a
// simple word-addressed internal bus. They are copied into shadow registers
// at every frame start, so writes made mid-frame take effect on the next frame.
//
// Ports:
//   clk            pixel/system clock, rising edge
//   rst_n          asynchronous active-low reset
//   ibus_cs        bus select
//   ibus_wr        bus write strobe (qualified by ibus_cs)
//   ibus_addr_7_2  register word address
//   ibus_wrdata    write data
//   ibus_rddata    combinational read data (0 when not selected or unmapped)
//   href           line valid, polarity set by CTRL[1]
//   vsync          frame sync, polarity set by CTRL[2]
//   data           pixel data, 0 outside the active window
//   frame_start    one-clock pulse on the first output cycle of each frame
//
// Register map (word address):
//   0x0 CTRL      {pat[4:3], vsync_pol[2], href_pol[1], enable[0]}
//   0x1 STATUS    {busy[0]} (read-only)
//   0x2 H_TOTAL   [13:0]
//   0x3 H_ACTIVE  [13:0]
//   0x4 V_TOTAL   [13:0]
//   0x5 V_ACTIVE  [13:0]
//   0x6 H_BEGIN   [13:0]
//   0x7 {V_BEGIN[29:16], VS_WIDTH[13:0]}
//   0x8 FRAME_CNT [FCW-1:0] (read-only)
//   0x9 CONST     [DW-1:0]
// DW and FCW are expected to be at most 32.
module dvp_gen #(
    parameter int DW  = 8,
    parameter int FCW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ibus_cs,
    input  logic          ibus_wr,
    input  logic [5:0]    ibus_addr_7_2,
    input  logic [31:0]   ibus_wrdata,
    output logic [31:0]   ibus_rddata,
    output logic          href,
    output logic          vsync,
    output logic [DW-1:0] data,
    output logic          frame_start
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Programmable registers
    logic [4:0]     ctrl;
    logic [13:0]    h_total, h_active, h_begin;
    logic [13:0]    v_total, v_active, v_begin, vs_width;
    logic [DW-1:0]  const_val;
    logic [FCW-1:0] frame_cnt;

    // Per-frame shadow copies
    logic [13:0]    sh_h_total, sh_h_active, sh_h_begin;
    logic [13:0]    sh_v_total, sh_v_active, sh_v_begin, sh_vs_width;
    logic [1:0]     sh_pat;
    logic [DW-1:0]  sh_const;

    state_t      state, state_nxt;
    logic [13:0] h_cnt_p0, v_cnt_p0, h_cnt_nxt, v_cnt_nxt;
    logic        load_shadow;
    logic        h_wrap, v_wrap;

    logic        hr_p0, vs_p0, fs_p0;
    logic [DW-1:0] pix_p0;
    logic [13:0] px_idx, ln_idx;
    logic [14:0] h_end, v_end;

    logic        wr_en;
    logic        unused_wrdata;

    assign wr_en         = ibus_cs & ibus_wr;
    assign unused_wrdata = &{1'b0, ibus_wrdata[31:30], ibus_wrdata[15:14]};

    function automatic logic [DW-1:0] pat_data(
        input logic [1:0]    pat,
        input logic [13:0]   px,
        input logic [13:0]   ln,
        input logic [DW-1:0] cst
    );
        logic [DW-1:0] r;
        case (pat)
            2'd0:    r = DW'(px);
            2'd1:    r = DW'(ln);
            2'd2:    r = cst;
            default: r = (px[3] ^ ln[3]) ? {DW{1'b1}} : {DW{1'b0}};
        endcase
        return r;
    endfunction

    // Register file and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= 5'd0;
            h_total   <= 14'd16;
            h_active  <= 14'd8;
            h_begin   <= 14'd4;
            v_total   <= 14'd8;
            v_active  <= 14'd4;
            v_begin   <= 14'd2;
            vs_width  <= 14'd1;
            const_val <= '0;
            frame_cnt <= '0;
        end else begin
            if (wr_en) begin
                case (ibus_addr_7_2)
                    6'h0: ctrl     <= ibus_wrdata[4:0];
                    6'h2: h_total  <= ibus_wrdata[13:0];
                    6'h3: h_active <= ibus_wrdata[13:0];
                    6'h4: v_total  <= ibus_wrdata[13:0];
                    6'h5: v_active <= ibus_wrdata[13:0];
                    6'h6: h_begin  <= ibus_wrdata[13:0];
                    6'h7: begin
                        v_begin  <= ibus_wrdata[29:16];
                        vs_width <= ibus_wrdata[13:0];
                    end
                    6'h9: const_val <= ibus_wrdata[DW-1:0];
                    default: ;
                endcase
            end
            // Counted on the same edge that raises frame_start.
            if (fs_p0) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        ibus_rddata = 32'd0;
        if (ibus_cs) begin
            case (ibus_addr_7_2)
                6'h0: ibus_rddata[4:0]     = ctrl;
                6'h1: ibus_rddata[0]       = (state == RUN);
                6'h2: ibus_rddata[13:0]    = h_total;
                6'h3: ibus_rddata[13:0]    = h_active;
                6'h4: ibus_rddata[13:0]    = v_total;
                6'h5: ibus_rddata[13:0]    = v_active;
                6'h6: ibus_rddata[13:0]    = h_begin;
                6'h7: begin
                    ibus_rddata[29:16] = v_begin;
                    ibus_rddata[13:0]  = vs_width;
                end
                6'h8: ibus_rddata[FCW-1:0] = frame_cnt;
                6'h9: ibus_rddata[DW-1:0]  = const_val;
                default: ;
            endcase
        end
    end

    // Stage p0: raster counters and state
    // A total of 0 gives 0-1 = 16383, i.e. a 16384-long period.
    assign h_wrap = (h_cnt_p0 == sh_h_total - 14'd1);
    assign v_wrap = (v_cnt_p0 == sh_v_total - 14'd1);

    always_comb begin
        state_nxt   = state;
        h_cnt_nxt   = h_cnt_p0;
        v_cnt_nxt   = v_cnt_p0;
        load_shadow = 1'b0;
        case (state)
            IDLE: begin
                h_cnt_nxt = 14'd0;
                v_cnt_nxt = 14'd0;
                if (ctrl[0]) begin
                    state_nxt   = RUN;
                    load_shadow = 1'b1;
                end
            end
            RUN: begin
                if (h_wrap) begin
                    h_cnt_nxt = 14'd0;
                    if (v_wrap) begin
                        // Frame boundary: enable is only looked at here, so a
                        // cleared enable lets the current frame finish.
                        v_cnt_nxt   = 14'd0;
                        load_shadow = 1'b1;
                        if (!ctrl[0]) state_nxt = IDLE;
                    end else begin
                        v_cnt_nxt = v_cnt_p0 + 14'd1;
                    end
                end else begin
                    h_cnt_nxt = h_cnt_p0 + 14'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            h_cnt_p0 <= 14'd0;
            v_cnt_p0 <= 14'd0;
        end else begin
            state    <= state_nxt;
            h_cnt_p0 <= h_cnt_nxt;
            v_cnt_p0 <= v_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_h_total  <= 14'd16;
            sh_h_active <= 14'd8;
            sh_h_begin  <= 14'd4;
            sh_v_total  <= 14'd8;
            sh_v_active <= 14'd4;
            sh_v_begin  <= 14'd2;
            sh_vs_width <= 14'd1;
            sh_pat      <= 2'd0;
            sh_const    <= '0;
        end else if (load_shadow) begin
            sh_h_total  <= h_total;
            sh_h_active <= h_active;
            sh_h_begin  <= h_begin;
            sh_v_total  <= v_total;
            sh_v_active <= v_active;
            sh_v_begin  <= v_begin;
            sh_vs_width <= vs_width;
            sh_pat      <= ctrl[4:3];
            sh_const    <= const_val;
        end
    end

    // Window ends are 15 bits wide so begin+active never wraps; anything
    // past the total is simply never reached by the counters.
    assign h_end  = {1'b0, sh_h_begin} + {1'b0, sh_h_active};
    assign v_end  = {1'b0, sh_v_begin} + {1'b0, sh_v_active};
    assign px_idx = h_cnt_p0 - sh_h_begin;
    assign ln_idx = v_cnt_p0 - sh_v_begin;

    assign hr_p0  = (state == RUN)
                 && (v_cnt_p0 >= sh_v_begin) && ({1'b0, v_cnt_p0} < v_end)
                 && (h_cnt_p0 >= sh_h_begin) && ({1'b0, h_cnt_p0} < h_end);
    assign vs_p0  = (state == RUN) && (v_cnt_p0 < sh_vs_width);
    assign fs_p0  = (state == RUN) && (h_cnt_p0 == 14'd0) && (v_cnt_p0 == 14'd0);
    assign pix_p0 = hr_p0 ? pat_data(sh_pat, px_idx, ln_idx, sh_const) : '0;

    // Stage p1: registered outputs, polarity applied from live CTRL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href        <= 1'b0;
            vsync       <= 1'b0;
            data        <= '0;
            frame_start <= 1'b0;
        end else begin
            href        <= hr_p0 ^ ctrl[1];
            vsync       <= vs_p0 ^ ctrl[2];
            data        <= pix_p0;
            frame_start <= fs_p0;
        end
    end

endmodule

// File: tb/tb_dvp_gen.sv
module tb_dvp_gen;
    localparam int DW  = 8;
    localparam int FCW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ibus_cs = 1'b0;
    logic          ibus_wr = 1'b0;
    logic [5:0]    ibus_addr_7_2 = 6'd0;
    logic [31:0]   ibus_wrdata = 32'd0;
    logic [31:0]   ibus_rddata;
    logic          href, vsync, frame_start;
    logic [DW-1:0] data;

    dvp_gen #(.DW(DW), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n), .ibus_cs(ibus_cs), .ibus_wr(ibus_wr),
        .ibus_addr_7_2(ibus_addr_7_2), .ibus_wrdata(ibus_wrdata),
        .ibus_rddata(ibus_rddata), .href(href), .vsync(vsync),
        .data(data), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         fs;
        int         off;
        logic [7:0] d;
        bit         vs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   hpol  = 1'b0;
    bit   vpol  = 1'b0;
    int   cyc   = 0;
    int   gap   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected events of one frame: a frame_start record, then one record
    // per active pixel with its cycle offset from frame_start.
    task automatic push_frame(input int ht, input int hb, input int ha,
                              input int vt, input int vb, input int va,
                              input int vsw, input int pat,
                              input logic [7:0] cst, input int gp);
        exp_t r;
        int px, ln;
        r.fs = 1'b1; r.off = gp; r.d = 8'h00; r.vs = (vsw > 0);
        q.push_back(r);
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht; h++) begin
                if (v >= vb && v < vb + va && h >= hb && h < hb + ha) begin
                    px = h - hb;
                    ln = v - vb;
                    case (pat)
                        0: r.d = px[7:0];
                        1: r.d = ln[7:0];
                        2: r.d = cst;
                        default: r.d = (px[3] ^ ln[3]) ? 8'hFF : 8'h00;
                    endcase
                    r.fs  = 1'b0;
                    r.off = v * ht + h;
                    r.vs  = (v < vsw);
                    q.push_back(r);
                end
            end
        end
    endtask

    // Monitor: pops one expected record per observed frame_start / active pixel.
    always @(negedge clk) begin : mon
        bit   act;
        exp_t r;
        if (rst_n) begin
            act = href ^ hpol;
            cyc++;
            if (frame_start) begin
                gap = cyc;
                cyc = 0;
            end
            if (!act) chk("idle_data", {24'd0, data}, 32'd0);
            if (frame_start || act) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output cyc=%0d fs=%0b href=%0b data=%h required=none",
                             cyc, frame_start, href, data);
                end else begin
                    r = q.pop_front();
                    chk("fs_flag", {31'd0, frame_start}, {31'd0, r.fs});
                    if (r.fs) begin
                        if (r.off != 0) chk("frame_gap", gap, r.off);
                    end else begin
                        chk("pix_pos", cyc, r.off);
                        chk("pix_data", {24'd0, data}, {24'd0, r.d});
                    end
                    chk("vsync", {31'd0, vsync ^ vpol}, {31'd0, r.vs});
                end
            end
        end
    end

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr_7_2 = a; ibus_wrdata = d;
        @(posedge clk);
        #1;
        ibus_cs = 1'b0; ibus_wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr_7_2 = a;
        #1;
        chk(name, ibus_rddata, exp);
        ibus_cs = 1'b0;
    endtask

    task automatic wait_fs(input int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            seen = frame_start;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_fs got=timeout required=frame_start within %0d", lim);
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_href", {31'd0, href}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("def_ctrl", 6'h0, 32'd0);
        rd_chk("def_htotal", 6'h2, 32'd16);
        rd_chk("def_hactive", 6'h3, 32'd8);
        rd_chk("def_vtotal", 6'h4, 32'd8);
        rd_chk("def_vactive", 6'h5, 32'd4);
        rd_chk("def_hbegin", 6'h6, 32'd4);
        rd_chk("def_reg7", 6'h7, 32'h0002_0001);
        rd_chk("def_fcnt", 6'h8, 32'd0);
        rd_chk("unmapped", 6'hA, 32'd0);
        ibus_cs = 1'b0; ibus_addr_7_2 = 6'h3; #1;
        chk("rd_nocs", ibus_rddata, 32'd0);

        // Default raster, two frames, disable mid second frame
        push_frame(16, 4, 8, 8, 2, 4, 1, 0, 8'h00, 0);
        push_frame(16, 4, 8, 8, 2, 4, 1, 0, 8'h00, 128);
        bus_write(6'h0, 32'd1);
        wait_fs(20);
        rd_chk("busy_run", 6'h1, 32'd1);
        repeat (15) @(negedge clk);
        chk("vs_last_hi", {31'd0, vsync}, 32'd1);
        @(negedge clk);
        chk("vs_first_lo", {31'd0, vsync}, 32'd0);
        repeat (19) @(negedge clk);
        chk("href_pre", {31'd0, href}, 32'd0);
        @(negedge clk);
        chk("href_first", {31'd0, href}, 32'd1);
        wait_fs(200);
        repeat (51) @(negedge clk);
        bus_write(6'h0, 32'd0);
        repeat (200) @(negedge clk);
        rd_chk("busy_idle", 6'h1, 32'd0);
        rd_chk("fcnt_2", 6'h8, 32'd2);
        chk("q_empty1", q.size(), 32'd0);
        repeat (200) @(negedge clk);
        rd_chk("fcnt_hold", 6'h8, 32'd2);

        // H_ACTIVE change mid-frame applies to the next frame
        push_frame(16, 4, 8, 8, 2, 4, 1, 0, 8'h00, 0);
        push_frame(16, 4, 12, 8, 2, 4, 1, 0, 8'h00, 128);
        bus_write(6'h0, 32'd1);
        wait_fs(20);
        repeat (10) @(negedge clk);
        bus_write(6'h3, 32'd12);
        wait_fs(200);
        repeat (30) @(negedge clk);
        bus_write(6'h0, 32'd0);
        repeat (200) @(negedge clk);
        chk("q_empty2", q.size(), 32'd0);
        rd_chk("fcnt_4", 6'h8, 32'd4);

        // Inverted polarities, idle and running
        bus_write(6'h0, 32'h6);
        @(posedge clk); #1;
        hpol = 1'b1; vpol = 1'b1;
        chk("inv_idle_href", {31'd0, href}, 32'd1);
        chk("inv_idle_vsync", {31'd0, vsync}, 32'd1);
        push_frame(16, 4, 12, 8, 2, 4, 1, 0, 8'h00, 0);
        bus_write(6'h0, 32'h7);
        wait_fs(20);
        chk("inv_fs_vsync", {31'd0, vsync}, 32'd0);
        chk("inv_fs_href", {31'd0, href}, 32'd1);
        repeat (20) @(negedge clk);
        bus_write(6'h0, 32'h6);
        repeat (200) @(negedge clk);
        chk("inv_end_href", {31'd0, href}, 32'd1);
        chk("inv_end_vsync", {31'd0, vsync}, 32'd1);
        chk("q_empty3", q.size(), 32'd0);
        bus_write(6'h0, 32'h0);
        @(posedge clk); #1;
        hpol = 1'b0; vpol = 1'b0;
        rd_chk("fcnt_5", 6'h8, 32'd5);

        // Checkerboard pattern
        bus_write(6'h2, 32'd32);
        bus_write(6'h3, 32'd16);
        bus_write(6'h4, 32'd12);
        bus_write(6'h5, 32'd10);
        push_frame(32, 4, 16, 12, 2, 10, 1, 3, 8'h00, 0);
        bus_write(6'h0, 32'h19);
        wait_fs(20);
        repeat (20) @(negedge clk);
        bus_write(6'h0, 32'h18);
        repeat (450) @(negedge clk);
        chk("q_empty4", q.size(), 32'd0);
        rd_chk("busy_idle4", 6'h1, 32'd0);
        rd_chk("fcnt_6", 6'h8, 32'd6);

        // Line-index pattern, then constant pattern (pat shadowed per frame)
        bus_write(6'h0, 32'h0);
        bus_write(6'h2, 32'd8);
        bus_write(6'h3, 32'd2);
        bus_write(6'h6, 32'd1);
        bus_write(6'h4, 32'd6);
        bus_write(6'h5, 32'd3);
        bus_write(6'h7, 32'h0001_0002);
        bus_write(6'h9, 32'hA5);
        rd_chk("rd_reg7", 6'h7, 32'h0001_0002);
        rd_chk("rd_const", 6'h9, 32'hA5);
        push_frame(8, 1, 2, 6, 1, 3, 2, 1, 8'hA5, 0);
        push_frame(8, 1, 2, 6, 1, 3, 2, 2, 8'hA5, 48);
        bus_write(6'h0, 32'h09);
        wait_fs(20);
        bus_write(6'h0, 32'h11);
        wait_fs(100);
        repeat (5) @(negedge clk);
        bus_write(6'h0, 32'h10);
        repeat (100) @(negedge clk);
        chk("q_empty5", q.size(), 32'd0);
        rd_chk("fcnt_8", 6'h8, 32'd8);

        // Asynchronous reset in the middle of an active line
        push_frame(8, 1, 2, 6, 1, 3, 2, 0, 8'hA5, 0);
        bus_write(6'h0, 32'h1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = href;
            end
            chk("pre_rst_href", {31'd0, seen}, 32'd1);
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_href", {31'd0, href}, 32'd0);
        chk("arst_vsync", {31'd0, vsync}, 32'd0);
        chk("arst_data", {24'd0, data}, 32'd0);
        chk("arst_fs", {31'd0, frame_start}, 32'd0);
        repeat (3) @(negedge clk);
        rd_chk("arst_ctrl", 6'h0, 32'd0);
        rd_chk("arst_busy", 6'h1, 32'd0);
        rd_chk("arst_htotal", 6'h2, 32'd16);
        rd_chk("arst_hactive", 6'h3, 32'd8);
        rd_chk("arst_vactive", 6'h5, 32'd4);
        rd_chk("arst_hbegin", 6'h6, 32'd4);
        rd_chk("arst_reg7", 6'h7, 32'h0002_0001);
        rd_chk("arst_fcnt", 6'h8, 32'd0);
        rd_chk("arst_const", 6'h9, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_href", {31'd0, href}, 32'd0);
        chk("q_empty6", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dvp_gen.md
DVP_GEN -- requirements
Module: dvp_gen

Interface
REQ-001 SHALL have parameter DW, default 8, pixel data width in bits.
REQ-002 SHALL have parameter FCW, default 16, frame counter width in bits.
REQ-003 SHALL have port clk  input  1  pixel/system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ibus_cs  input  1  internal bus select.
REQ-006 SHALL have port ibus_wr  input  1  internal bus write strobe, valid with ibus_cs.
REQ-007 SHALL have port ibus_addr_7_2  input  6  register word address.
REQ-008 SHALL have port ibus_wrdata  input  32  write data.
REQ-009 SHALL have port ibus_rddata  output  32  combinational read data; 0 when ibus_cs=0 or address unmapped.
REQ-010 SHALL have port href  output  DW-independent 1  generated line-valid, polarity per CTRL[1].
REQ-011 SHALL have port vsync  output  1  generated frame sync, polarity per CTRL[2].
REQ-012 SHALL have port data  output  DW  pixel data, 0 whenever internal href is inactive.
REQ-013 SHALL have port frame_start  output  1  one-clock pulse coincident with the first output cycle of each frame.

Function
REQ-014 SHALL decode registers (word address, writes when ibus_cs&ibus_wr): 0x0 CTRL {pat[4:3], vsync_pol[2], href_pol[1], enable[0]}; 0x1 STATUS RO {busy[0]}; 0x2 H_TOTAL[13:0]; 0x3 H_ACTIVE[13:0]; 0x4 V_TOTAL[13:0]; 0x5 V_ACTIVE[13:0]; 0x6 H_BEGIN[13:0]; 0x7 {V_BEGIN[29:16], VS_WIDTH[13:0]}; 0x8 FRAME_CNT RO [FCW-1:0]; 0x9 CONST[DW-1:0].
REQ-015 SHALL reset registers to: CTRL=0, H_TOTAL=16, H_ACTIVE=8, H_BEGIN=4, V_TOTAL=8, V_ACTIVE=4, V_BEGIN=2, VS_WIDTH=1, CONST=0, FRAME_CNT=0; unused read bits read 0.
REQ-016 SHALL run 14-bit counters h_cnt (pixel) and v_cnt (line) while busy: h_cnt increments each clock, wraps to 0 at h_cnt==H_TOTAL-1 (mod 2^14, so 0 means 16384); v_cnt increments on h wrap, wraps at V_TOTAL-1 likewise.
REQ-017 SHALL implement states IDLE and RUN: IDLE->RUN on the clock after enable is sampled 1, entering with h_cnt=v_cnt=0; RUN->IDLE when enable=0 at the frame wrap (h and v both wrapping); enable cleared mid-frame SHALL finish the current frame; enable re-set before the wrap SHALL continue without gap.
REQ-018 SHALL copy H_TOTAL, H_ACTIVE, H_BEGIN, V_TOTAL, V_ACTIVE, V_BEGIN, VS_WIDTH, pat and CONST into shadow registers on every cycle counters enter (0,0) from IDLE or by wrap; timing uses shadows only, so mid-frame writes take effect next frame.
REQ-019 SHALL compute internal vs = (v_cnt < VS_WIDTH); internal hr = (V_BEGIN <= v_cnt < V_BEGIN+V_ACTIVE) and (H_BEGIN <= h_cnt < H_BEGIN+H_ACTIVE), comparisons in 15-bit unsigned so sums never wrap; windows beyond H_TOTAL/V_TOTAL are truncated.
REQ-020 SHALL register href, vsync, data, frame_start one clock after the counter state they represent (latency 1); frame_start=1 for counter state (0,0).
REQ-021 SHALL generate data when hr=1 by pat: 0 = pixel index within active line (h_cnt-H_BEGIN) low DW bits; 1 = active line index (v_cnt-V_BEGIN) low DW bits; 2 = CONST; 3 = all-ones if bit3 of pixel index XOR bit3 of line index, else 0.
REQ-022 SHALL drive href=hr XOR CTRL[1], vsync=vs XOR CTRL[2]; polarity bits are not shadowed and apply from the next clock, also in IDLE (internal hr=vs=0, data=0).
REQ-023 SHALL increment FRAME_CNT (wrapping at 2^FCW) on every frame_start; busy SHALL equal (state==RUN).

Reset
REQ-024 SHALL on rst_n=0, at any time including mid-frame, immediately force state=IDLE, counters=0, all registers to REQ-015 values, href=0, vsync=0, data=0, frame_start=0.

Verification
REQ-025 Defaults, write CTRL=1 -> frame_start every 128 clocks, vsync high for first 16 clocks of frame, href high 8 clocks at h_cnt 4..11 on lines 2..5, pat0 data 0..7.
REQ-026 Write CTRL=0 at h_cnt=5,v_cnt=3 -> frame completes, busy=0 after wrap, no further frame_start; FRAME_CNT unchanged thereafter.
REQ-027 Write H_ACTIVE=12 mid-frame -> current frame keeps 8-pixel lines, next frame 12 pixels (h_cnt 4..15).
REQ-028 CTRL=0x07 (both inverted, running) -> href/vsync exact complements of REQ-025 waveform; idle levels 1.
REQ-029 pat=3, H_ACTIVE=16, H_TOTAL=32 -> data 0x00 for pixels 0..7 and 0xFF for 8..15 on line 0, inverted on line 8 when V_ACTIVE>8.
REQ-030 Assert rst_n low mid-line with href active -> outputs 0 asynchronously, registers read defaults, busy=0.
